encode148_latch: RTL and testbench
==================================

ENCODE148_LATCH -- requirements
Module: encode148_latch

Purpose: registered 8-to-3 priority encoder with per-line request capture and acknowledge handshake; the encoding counterpart to the 3-to-8 decoder in the 74LSXX library.

Interface
REQ-001 SHALL have port: clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port: EI_n  input  1  enable input, active-low; 1 suppresses presentation.
REQ-004 SHALL have port: I_n  input  8  request lines, active-low; I_n[7] highest priority, I_n[0] lowest.
REQ-005 SHALL have port: ack  input  1  acknowledge pulse from consumer, active-high.
REQ-006 SHALL have port: A_n  output  3  encoded index of presented request, active-low (index 5 -> 3'b010).
REQ-007 SHALL have port: GS_n  output  1  group select, low while a request is presented.
REQ-008 SHALL have port: EO_n  output  1  enable output, low when enabled, idle and nothing pending.
REQ-009 SHALL have port: valid  output  1  high while A_n holds a presented request.
REQ-010 SHALL have port: pending  output  8  captured-but-unserved request bits, active-high.

Function
REQ-011 SHALL register I_n every edge into in_q; a falling edge on line i is in_q[i]==1 and I_n[i]==0 at the same edge.
REQ-012 SHALL set pending[i] at the edge on which a falling edge of line i is detected; a line held low sets pending only once.
REQ-013 SHALL capture requests regardless of EI_n.
REQ-014 SHALL implement a two-state FSM: IDLE and PRESENT.
REQ-015 In IDLE with EI_n==0 and pending!=0, SHALL select the highest set pending index, load ~index into A_n, set valid=1 and GS_n=0, and enter PRESENT at that edge.
REQ-016 Latency: line falls before edge k -> pending set after edge k -> valid=1 after edge k+1.
REQ-017 In PRESENT, A_n SHALL hold stable; higher-priority arrivals SHALL NOT preempt the presented index.
REQ-018 In PRESENT with ack==1 at an edge, SHALL clear pending[presented index], drive valid=0, GS_n=1, A_n=3'b111, and return to IDLE.
REQ-019 After an ack, the next request SHALL be presented no earlier than the following edge (valid low for at least one cycle between requests).
REQ-020 ack in IDLE SHALL be ignored.
REQ-021 New falling edge on the presented line coinciding with its ack clear: set SHALL win and pending bit remains 1.
REQ-022 EI_n==1 during PRESENT SHALL abort to IDLE at the next edge, with valid=0 and pending unchanged; ack at that same edge is ignored.
REQ-023 EO_n SHALL be 0 only when EI_n==0, state IDLE and pending==0; otherwise 1 (registered or combinational from registers, no path from I_n).
REQ-024 Simultaneous falling edges on several lines SHALL all set their pending bits at the same edge.

Reset
REQ-025 With rst_n==0 at an edge: state=IDLE, pending=8'h00, in_q=8'hFF, A_n=3'b111, GS_n=1, valid=0.
REQ-026 Lines held low through reset release SHALL NOT set pending (in_q reset high, but I_n low at first post-reset edge counts as falling edge) -- therefore in_q SHALL load I_n during reset so only post-reset transitions are detected.
REQ-027 Reset asserted mid-PRESENT SHALL drop valid and clear all pending at that edge, overriding ack and captures.

Verification
REQ-028 Single request: EI_n=0, I_n 8'hFF -> 8'hDF (line 5) -> pending=8'h20 after 1 edge, valid=1 and A_n=3'b010 after 2 edges; ack one cycle -> pending=0, valid=0, EO_n=0.
REQ-029 Priority: lines 2 and 6 fall same cycle -> pending=8'h44, A_n=3'b001 (6); ack -> one idle cycle, then A_n=3'b101 (2); ack -> EO_n=0.
REQ-030 No preemption: line 1 presented, line 7 falls -> A_n stays 3'b110 until ack, then A_n=3'b000.
REQ-031 Enable: EI_n=1, line 3 falls -> pending=8'h08, valid stays 0, EO_n=1; EI_n=0 -> valid=1, A_n=3'b100 next edge; EI_n=1 during PRESENT -> valid=0, pending=8'h08.
REQ-032 Reset: I_n=8'h00 held through reset release -> pending stays 8'h00, EO_n=0; reset during PRESENT -> valid=0, pending=0 next edge.
REQ-033 Ack/set collision: line 4 presented, line 4 rises then falls with fall coinciding with ack edge -> pending[4]=1, re-presented as A_n=3'b011 after idle cycle.

Source files
------------

// File: rtl/encode148_latch_if.sv
// Request/encode bus for encode148_latch: request lines, enable and ack in,
// encoded index, group select, enable-out, valid and pending flags out.
interface encode148_latch_if;
    logic       EI_n;
    logic [7:0] I_n;
    logic       ack;
    logic [2:0] A_n;
    logic       GS_n;
    logic       EO_n;
    logic       valid;
    logic [7:0] pending;

    modport master (
        output EI_n, I_n, ack,
        input  A_n, GS_n, EO_n, valid, pending
    );

    modport slave (
        input  EI_n, I_n, ack,
        output A_n, GS_n, EO_n, valid, pending
    );
endinterface

// File: rtl/encode148_latch.sv
// Registered 8-to-3 priority encoder: falling edges on I_n are captured as
// pending requests, presented one at a time, and retired by an ack pulse.
module encode148_latch (
    input  logic              clk,
    input  logic              rst_n,
    encode148_latch_if.slave  bus
);
    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t     r_state;
    logic [7:0] r_in_q;
    logic [7:0] r_pending;
    logic [2:0] r_idx;
    logic [2:0] r_a_n;
    logic       r_valid;
    logic       r_gs_n;

    logic [7:0] w_fall;
    logic [7:0] w_ack_clr;
    logic [2:0] w_sel;
    logic       w_any;

    assign w_fall = r_in_q & ~bus.I_n;
    assign w_any  = |r_pending;

    // NOTE: w_sel gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        w_sel = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (r_pending[i]) w_sel = 3'(i);
        end
    end

    // Clearing the presented bit is OR'ed with new falls, so a coincident set wins.
    always_comb begin
        w_ack_clr = 8'h00;
        if (r_state == PRESENT && !bus.EI_n && bus.ack) w_ack_clr = 8'b1 << r_idx;
    end

    always_ff @(posedge clk) begin
        // NOTE: in_q tracks I_n even in reset so lines held low across release are not seen as new falls.
        r_in_q <= bus.I_n;
        if (!rst_n) begin
            r_state   <= IDLE;
            r_pending <= 8'h00;
            r_idx     <= 3'd0;
            r_a_n     <= 3'b111;
            r_valid   <= 1'b0;
            r_gs_n    <= 1'b1;
        end else begin
            r_pending <= (r_pending & ~w_ack_clr) | w_fall;
            case (r_state)
                IDLE: begin
                    if (!bus.EI_n && w_any) begin
                        r_idx   <= w_sel;
                        r_a_n   <= ~w_sel;
                        r_valid <= 1'b1;
                        r_gs_n  <= 1'b0;
                        r_state <= PRESENT;
                    end
                end
                PRESENT: begin
                    // Disable aborts ahead of ack; the presented request stays pending.
                    if (bus.EI_n || bus.ack) begin
                        r_a_n   <= 3'b111;
                        r_valid <= 1'b0;
                        r_gs_n  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.A_n     = r_a_n;
    assign bus.GS_n    = r_gs_n;
    assign bus.valid   = r_valid;
    assign bus.pending = r_pending;
    assign bus.EO_n    = ~(~bus.EI_n & (r_state == IDLE) & ~w_any);
endmodule

// File: tb/tb_encode148_latch.sv
// Directed bench for encode148_latch: each step pushes its expected post-edge
// outputs to a scoreboard queue, which is popped and compared after the edge.
module tb_encode148_latch;
    logic clk;
    logic rst_n;

    encode148_latch_if bus ();

    encode148_latch u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string      tag;
        logic [7:0] pending;
        logic       valid;
        logic [2:0] a_n;
        logic       gs_n;
        logic       eo_n;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input string field, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic ei, input logic [7:0] in_n, input logic ak,
                        input logic [7:0] e_pend, input logic e_valid, input logic [2:0] e_a_n,
                        input logic e_eo_n, input string tag);
        exp_t e;
        exp_t got;
        rst_n    = rst;
        bus.EI_n = ei;
        bus.I_n  = in_n;
        bus.ack  = ak;
        e.tag     = tag;
        e.pending = e_pend;
        e.valid   = e_valid;
        e.a_n     = e_a_n;
        e.gs_n    = ~e_valid;
        e.eo_n    = e_eo_n;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        checks++;
        assert (sb_q.size() > 0) else begin
            errors++;
            $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
        end
        if (sb_q.size() > 0) begin
            got = sb_q.pop_front();
            chk(got.tag, "pending", bus.pending, got.pending);
            chk(got.tag, "valid",   {7'd0, bus.valid}, {7'd0, got.valid});
            chk(got.tag, "A_n",     {5'd0, bus.A_n},   {5'd0, got.a_n});
            chk(got.tag, "GS_n",    {7'd0, bus.GS_n},  {7'd0, got.gs_n});
            chk(got.tag, "EO_n",    {7'd0, bus.EO_n},  {7'd0, got.eo_n});
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        bus.EI_n = 1'b0;
        bus.I_n  = 8'hFF;
        bus.ack  = 1'b0;

        //   rst  EI_n  I_n    ack  pending valid A_n     EO_n  tag
        step(0, 0, 8'hFF, 0, 8'h00, 0, 3'b111, 0, "reset0");
        step(0, 0, 8'hFF, 0, 8'h00, 0, 3'b111, 0, "reset1");
        step(1, 0, 8'hFF, 0, 8'h00, 0, 3'b111, 0, "idle");

        // Single request on line 5
        step(1, 0, 8'hDF, 0, 8'h20, 0, 3'b111, 1, "single_cap");
        step(1, 0, 8'hDF, 0, 8'h20, 1, 3'b010, 1, "single_pres");
        step(1, 0, 8'hDF, 1, 8'h00, 0, 3'b111, 0, "single_ack");
        step(1, 0, 8'hFF, 0, 8'h00, 0, 3'b111, 0, "single_rise");

        // Simultaneous lines 6 and 2, priority order
        step(1, 0, 8'hBB, 0, 8'h44, 0, 3'b111, 1, "prio_cap");
        step(1, 0, 8'hBB, 0, 8'h44, 1, 3'b001, 1, "prio_pres6");
        step(1, 0, 8'hBB, 1, 8'h04, 0, 3'b111, 1, "prio_ack6");
        step(1, 0, 8'hBB, 0, 8'h04, 1, 3'b101, 1, "prio_pres2");
        step(1, 0, 8'hBB, 1, 8'h00, 0, 3'b111, 0, "prio_ack2");
        step(1, 0, 8'hFF, 0, 8'h00, 0, 3'b111, 0, "prio_rise");

        // No preemption: line 1 presented, line 7 arrives
        step(1, 0, 8'hFD, 0, 8'h02, 0, 3'b111, 1, "npre_cap1");
        step(1, 0, 8'hFD, 0, 8'h02, 1, 3'b110, 1, "npre_pres1");
        step(1, 0, 8'h7D, 0, 8'h82, 1, 3'b110, 1, "npre_cap7");
        step(1, 0, 8'h7D, 0, 8'h82, 1, 3'b110, 1, "npre_hold");
        step(1, 0, 8'h7D, 1, 8'h80, 0, 3'b111, 1, "npre_ack1");
        step(1, 0, 8'h7D, 0, 8'h80, 1, 3'b000, 1, "npre_pres7");
        step(1, 0, 8'h7D, 1, 8'h00, 0, 3'b111, 0, "npre_ack7");
        step(1, 0, 8'hFF, 0, 8'h00, 0, 3'b111, 0, "npre_rise");

        // Enable gating, abort with coincident ack ignored
        step(1, 1, 8'hF7, 0, 8'h08, 0, 3'b111, 1, "en_cap");
        step(1, 1, 8'hF7, 0, 8'h08, 0, 3'b111, 1, "en_blocked");
        step(1, 0, 8'hF7, 0, 8'h08, 1, 3'b100, 1, "en_pres");
        step(1, 1, 8'hF7, 1, 8'h08, 0, 3'b111, 1, "en_abort");
        step(1, 0, 8'hF7, 0, 8'h08, 1, 3'b100, 1, "en_repres");
        step(1, 0, 8'hF7, 1, 8'h00, 0, 3'b111, 0, "en_ack");
        step(1, 0, 8'hFF, 0, 8'h00, 0, 3'b111, 0, "en_rise");

        // Ack/set collision on line 4
        step(1, 0, 8'hEF, 0, 8'h10, 0, 3'b111, 1, "col_cap");
        step(1, 0, 8'hEF, 0, 8'h10, 1, 3'b011, 1, "col_pres");
        step(1, 0, 8'hFF, 0, 8'h10, 1, 3'b011, 1, "col_rise");
        step(1, 0, 8'hEF, 1, 8'h10, 0, 3'b111, 1, "col_ack_fall");
        step(1, 0, 8'hEF, 0, 8'h10, 1, 3'b011, 1, "col_repres");
        step(1, 0, 8'hEF, 1, 8'h00, 0, 3'b111, 0, "col_ack");
        step(1, 0, 8'hFF, 0, 8'h00, 0, 3'b111, 0, "col_rise2");

        // Ack in IDLE ignored; line 0 encodes as 3'b111 with GS_n low
        step(1, 1, 8'hFE, 0, 8'h01, 0, 3'b111, 1, "idle_cap0");
        step(1, 1, 8'hFE, 1, 8'h01, 0, 3'b111, 1, "idle_ack");
        step(1, 0, 8'hFE, 0, 8'h01, 1, 3'b111, 1, "line0_pres");
        step(1, 0, 8'hFE, 1, 8'h00, 0, 3'b111, 0, "line0_ack");
        step(1, 0, 8'hFF, 0, 8'h00, 0, 3'b111, 0, "line0_rise");

        // Lines held low through reset release
        step(0, 0, 8'h00, 0, 8'h00, 0, 3'b111, 0, "rlow_rst0");
        step(0, 0, 8'h00, 0, 8'h00, 0, 3'b111, 0, "rlow_rst1");
        step(1, 0, 8'h00, 0, 8'h00, 0, 3'b111, 0, "rlow_rel0");
        step(1, 0, 8'h00, 0, 8'h00, 0, 3'b111, 0, "rlow_rel1");
        step(1, 0, 8'hFF, 0, 8'h00, 0, 3'b111, 0, "rlow_rise");

        // Reset mid-PRESENT overrides ack and a new capture
        step(1, 0, 8'h7E, 0, 8'h81, 0, 3'b111, 1, "rmid_cap");
        step(1, 0, 8'h7E, 0, 8'h81, 1, 3'b000, 1, "rmid_pres");
        step(0, 0, 8'h7C, 1, 8'h00, 0, 3'b111, 0, "rmid_rst");
        step(1, 0, 8'hFF, 0, 8'h00, 0, 3'b111, 0, "rmid_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
